sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Arbitrates the fetch stage and the load/store stage onto one single-port synchronous SRAM, so the core runs on a unified memory with one read latency. Sits between the core's instruction-side and data-side SRAM ports and the physical RAM. Data requests win by default, and a starvation counter bounds how long fetch can wait. The block buffers one read response per requester so a stalled pipeline never loses returned data, and it drives per-side stall requests into CTRL.

## Interface
- MAX_WAIT, 4: consecutive cycles an eligible, ungranted instruction request may lose before it takes priority; range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- inst_req / data_req  in  1  request valid; held stable with its payload until granted.
- inst_wen / data_wen  in  4  byte write enables; 0 = read.
- inst_addr / data_addr  in  32  byte address, passed through unchanged.
- inst_wdata / data_wdata  in  32  write data.
- inst_rready / data_rready  in  1  requester consumes the presented response this cycle.
- inst_gnt / data_gnt  out  1  request accepted this cycle (combinational).
- inst_rvalid / data_rvalid  out  1  read response presented.
- inst_rdata / data_rdata  out  32  read response data.
- inst_stallreq / data_stallreq  out  1  = req & ~gnt.
- ram_en  out  1  = inst_gnt | data_gnt.
- ram_wen  out  4  granted side's wen; 0 when idle.
- ram_addr / ram_wdata  out  32  granted side's payload; 0 when idle.
- ram_rdata  in  32  data for the address presented one cycle earlier.

## Operation
- Per side, a response state {EMPTY, LIVE, HELD} plus a 32-bit hold register.
- Eligibility: a side is eligible if req=1 and either its response state is EMPTY, or the state is non-EMPTY and rready=1 this cycle.
- Arbitration (combinational):
  - Exactly one or zero grants per cycle.
  - If both sides are eligible, data wins unless wait_cnt == MAX_WAIT, in which case inst wins.
  - A lone eligible side always wins.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each cycle inst is eligible but not granted.
  - Clears on inst grant.
  - Holds otherwise.
- Response state transitions:
  - Grant of a read moves the side to LIVE next cycle.
  - Grant of a write with rready=1 moves it to EMPTY.
  - LIVE: rvalid=1 and rdata=ram_rdata (pass-through). With rready=0, capture ram_rdata into the hold register and go to HELD. With rready=1, go to EMPTY, or to LIVE if a new read is granted the same cycle.
  - HELD: rvalid=1 and rdata=hold register. Leave on rready=1, with the same new-grant rule as LIVE.
  - EMPTY: rvalid=0 and rdata=0.
- Writes produce no response. The grant is the completion.
- The RAM is never driven by both sides. An ungranted side's payload never reaches the ram_* outputs.

## Timing
- Reset: wait_cnt=0, both response states EMPTY, hold registers 0, so all rvalid/rdata are 0.
  - Grants and ram_* outputs are combinational and follow the inputs even while rst=1.
  - A read granted in the cycle before reset is discarded; its ram_rdata is never presented.
- Read latency: grant in cycle T, rvalid=1 in T+1 (pass-through). If not consumed, the data is held from T+2 until the cycle after rready.
- Throughput: with rready tied high, one access per cycle sustained; back-to-back reads on the same side are allowed.
- Starvation bound: an eligible inst request is granted within MAX_WAIT+1 cycles of first losing.
- If both sides have a HELD response and neither consumes it, neither side is eligible and ram_en=0.

## Test plan
- Reset, then idle: all outputs 0 and wait_cnt=0. Assert rst mid-read: no rvalid follows.
- Lone inst read of 0xBFC00000, rready=1, RAM returning 0x3C080001: inst_gnt in T, inst_rvalid=1 with rdata 0x3C080001 in T+1 only.
- Simultaneous inst read and data write (wen=0xF, addr 0x10, wdata 0xDEADBEEF): data_gnt first with ram_wen=0xF and inst_stallreq=1; inst granted next cycle; no data_rvalid at any point.
- data_req held continuously, inst_req continuous, MAX_WAIT=4: inst loses 4 cycles, is granted in cycle 5, and wait_cnt returns to 0.
- Inst read with inst_rready=0 for 3 cycles while RAM output changes: rdata stays at the value from T+1, a new inst_req is not granted, and inst_stallreq=1. On rready=1 the new request is granted that same cycle.
- 8 back-to-back data reads at addr 0,4,…,28 with rready=1: 8 consecutive gnts, then 8 consecutive rvalid cycles with matching data.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bundles the instruction-side and data-side SRAM request/response ports
// together with the physical single-port RAM port.
//   slave  : view used by the arbiter (requests in, grants/responses/RAM drive out)
//   master : view used by whatever drives the requests and models the RAM
interface sram_port_arbiter_if;
  // Instruction side
  logic        inst_req;
  logic [3:0]  inst_wen;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_rready;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        inst_stallreq;
  // Data side
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rready;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_stallreq;
  // Physical RAM
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  inst_req, inst_wen, inst_addr, inst_wdata, inst_rready,
    input  data_req, data_wen, data_addr, data_wdata, data_rready,
    input  ram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata, inst_stallreq,
    output data_gnt, data_rvalid, data_rdata, data_stallreq,
    output ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output inst_req, inst_wen, inst_addr, inst_wdata, inst_rready,
    output data_req, data_wen, data_addr, data_wdata, data_rready,
    output ram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata, inst_stallreq,
    input  data_gnt, data_rvalid, data_rdata, data_stallreq,
    input  ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port synchronous
// SRAM with a one-cycle read latency. Data wins ties unless fetch has already
// lost MAX_WAIT consecutive eligible cycles. Each side keeps one read response
// (pass-through in the first cycle, then a hold register) so a stalled
// requester never loses returned data.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   bus_io : request/response ports of both sides plus the RAM port (slave view)
module sram_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4  // 1..15
) (
  input logic                  clk,
  input logic                  rst,
  sram_port_arbiter_if.slave   bus_io
);

  typedef enum logic [1:0] {StEmpty, StLive, StHeld} rsp_st_e;

  localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

  rsp_st_e     inst_st_q, inst_st_d;
  rsp_st_e     data_st_q, data_st_d;
  logic [31:0] inst_hold_q, inst_hold_d;
  logic [31:0] data_hold_q, data_hold_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic inst_elig, data_elig;
  logic inst_gnt, data_gnt;

  // Next response state for one side. A new read grant always reopens the
  // response; otherwise an outstanding response is either consumed or parked.
  function automatic rsp_st_e rsp_next(rsp_st_e st, logic gnt, logic [3:0] wen, logic rready);
    rsp_st_e nxt;
    nxt = StEmpty;
    if (gnt) begin
      nxt = (wen == 4'h0) ? StLive : StEmpty;
    end else begin
      case (st)
        StLive, StHeld: nxt = rready ? StEmpty : StHeld;
        default:        nxt = StEmpty;
      endcase
    end
    return nxt;
  endfunction

  // A side with an unconsumed response may only issue if it frees the slot now.
  always_comb begin
    inst_elig = bus_io.inst_req & ((inst_st_q == StEmpty) | bus_io.inst_rready);
    data_elig = bus_io.data_req & ((data_st_q == StEmpty) | bus_io.data_rready);
    inst_gnt  = inst_elig & (~data_elig | (wait_cnt_q == MaxWaitCnt));
    data_gnt  = data_elig & ~inst_gnt;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (inst_gnt) begin
      wait_cnt_d = 4'h0;
    end else if (inst_elig && (wait_cnt_q != MaxWaitCnt)) begin
      wait_cnt_d = wait_cnt_q + 4'h1;
    end
  end

  always_comb begin
    inst_st_d   = rsp_next(inst_st_q, inst_gnt, bus_io.inst_wen, bus_io.inst_rready);
    data_st_d   = rsp_next(data_st_q, data_gnt, bus_io.data_wen, bus_io.data_rready);
    inst_hold_d = inst_hold_q;
    data_hold_d = data_hold_q;
    // RAM output is only valid for one cycle; park it if not consumed now.
    if ((inst_st_q == StLive) && !bus_io.inst_rready) inst_hold_d = bus_io.ram_rdata;
    if ((data_st_q == StLive) && !bus_io.data_rready) data_hold_d = bus_io.ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_st_q   <= StEmpty;
      data_st_q   <= StEmpty;
      inst_hold_q <= 32'h0;
      data_hold_q <= 32'h0;
      wait_cnt_q  <= 4'h0;
    end else begin
      inst_st_q   <= inst_st_d;
      data_st_q   <= data_st_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Grants, stalls and the RAM mux.
  always_comb begin
    bus_io.inst_gnt      = inst_gnt;
    bus_io.data_gnt      = data_gnt;
    bus_io.inst_stallreq = bus_io.inst_req & ~inst_gnt;
    bus_io.data_stallreq = bus_io.data_req & ~data_gnt;
    bus_io.ram_en        = inst_gnt | data_gnt;
    bus_io.ram_wen       = 4'h0;
    bus_io.ram_addr      = 32'h0;
    bus_io.ram_wdata     = 32'h0;
    if (inst_gnt) begin
      bus_io.ram_wen   = bus_io.inst_wen;
      bus_io.ram_addr  = bus_io.inst_addr;
      bus_io.ram_wdata = bus_io.inst_wdata;
    end else if (data_gnt) begin
      bus_io.ram_wen   = bus_io.data_wen;
      bus_io.ram_addr  = bus_io.data_addr;
      bus_io.ram_wdata = bus_io.data_wdata;
    end
  end

  // Responses.
  always_comb begin
    bus_io.inst_rvalid = (inst_st_q != StEmpty);
    bus_io.data_rvalid = (data_st_q != StEmpty);
    case (inst_st_q)
      StLive:  bus_io.inst_rdata = bus_io.ram_rdata;
      StHeld:  bus_io.inst_rdata = inst_hold_q;
      default: bus_io.inst_rdata = 32'h0;
    endcase
    case (data_st_q)
      StLive:  bus_io.data_rdata = bus_io.ram_rdata;
      StHeld:  bus_io.data_rdata = data_hold_q;
      default: bus_io.data_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter. The reference model
// treats each side as "one pending read value or nothing", keeps a word array
// as the RAM, and returns garbage on ram_rdata whenever the previous cycle was
// not a read, so a missing hold register shows up as wrong data.
module tb_sram_port_arbiter;
  localparam int unsigned MaxWait = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if bus_if ();

  sram_port_arbiter #(.MAX_WAIT(MaxWait)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the next cycle.
  logic        i_req, d_req, i_rr, d_rr, s_rst;
  logic [3:0]  i_wen, d_wen;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;

  // Reference model.
  bit          i_pend, d_pend;
  logic [31:0] i_pdata, d_pdata;
  int unsigned m_wait;
  logic [31:0] mem [64];
  logic [31:0] ram_next;
  bit          gi, gd;
  logic [31:0] obs_i_rdata;

  // Called at posedge+1: drive, check mid-cycle, advance model, go to next posedge+1.
  task automatic step();
    bit          ie, de;
    logic [3:0]  ewen;
    logic [31:0] eaddr, ewd;
    int          idx;
    bus_if.inst_req    = i_req;   bus_if.data_req    = d_req;
    bus_if.inst_wen    = i_wen;   bus_if.data_wen    = d_wen;
    bus_if.inst_addr   = i_addr;  bus_if.data_addr   = d_addr;
    bus_if.inst_wdata  = i_wdata; bus_if.data_wdata  = d_wdata;
    bus_if.inst_rready = i_rr;    bus_if.data_rready = d_rr;
    bus_if.ram_rdata   = ram_next;
    rst = s_rst;
    #4;
    ie = i_req && (!i_pend || i_rr);
    de = d_req && (!d_pend || d_rr);
    gi = ie && (!de || m_wait >= MaxWait);
    gd = de && !gi;
    ewen = gi ? i_wen : gd ? d_wen : 4'h0;
    eaddr = gi ? i_addr : gd ? d_addr : 32'h0;
    ewd = gi ? i_wdata : gd ? d_wdata : 32'h0;
    check("inst_gnt", 32'(bus_if.inst_gnt), 32'(gi));
    check("data_gnt", 32'(bus_if.data_gnt), 32'(gd));
    check("inst_stall", 32'(bus_if.inst_stallreq), 32'(i_req && !gi));
    check("data_stall", 32'(bus_if.data_stallreq), 32'(d_req && !gd));
    check("ram_en", 32'(bus_if.ram_en), 32'(gi || gd));
    check("ram_wen", 32'(bus_if.ram_wen), 32'(ewen));
    check("ram_addr", bus_if.ram_addr, eaddr);
    check("ram_wdata", bus_if.ram_wdata, ewd);
    check("inst_rvalid", 32'(bus_if.inst_rvalid), 32'(i_pend));
    check("data_rvalid", 32'(bus_if.data_rvalid), 32'(d_pend));
    check("inst_rdata", bus_if.inst_rdata, i_pend ? i_pdata : 32'h0);
    check("data_rdata", bus_if.data_rdata, d_pend ? d_pdata : 32'h0);
    obs_i_rdata = bus_if.inst_rdata;
    // RAM access
    ram_next = $urandom;
    if (gi || gd) begin
      idx = int'(eaddr[7:2]);
      if (ewen == 4'h0) begin
        ram_next = mem[idx];
      end else begin
        for (int b = 0; b < 4; b++) if (ewen[b]) mem[idx][8*b +: 8] = ewd[8*b +: 8];
      end
    end
    // Responses and starvation count
    if (s_rst) begin
      i_pend = 0; d_pend = 0; m_wait = 0;
    end else begin
      if (gi) begin
        i_pend = (i_wen == 4'h0); i_pdata = ram_next;
      end else if (i_pend && i_rr) i_pend = 0;
      if (gd) begin
        d_pend = (d_wen == 4'h0); d_pdata = ram_next;
      end else if (d_pend && d_rr) d_pend = 0;
      if (gi) m_wait = 0;
      else if (ie && m_wait < MaxWait) m_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 0; d_req = 0; i_wen = 0; d_wen = 0; i_addr = 0; d_addr = 0;
    i_wdata = 0; d_wdata = 0; i_rr = 1; d_rr = 1; s_rst = 0;
  endtask

  int gcycle;

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    mem[0] = 32'h3C080001;
    ram_next = $urandom;
    i_pend = 0; d_pend = 0; m_wait = 0; gi = 0; gd = 0;
    idle();
    s_rst = 1;
    rst = 1;
    @(posedge clk);
    #1;

    // Reset then idle
    step(); step();
    s_rst = 0;
    step(); step();

    // Lone boot-vector read
    i_req = 1; i_addr = 32'hBFC00000;
    step();
    idle();
    step();
    check("boot_rdata", obs_i_rdata, 32'h3C080001);
    step();

    // Inst read against data write: data first, inst next cycle
    i_req = 1; i_addr = 32'h0000_0020;
    d_req = 1; d_wen = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    step();
    d_req = 0; d_wen = 0;
    step();
    idle();
    step(); step();

    // Starvation: data reads every cycle, inst read held until granted
    s_rst = 1; step(); s_rst = 0;
    gcycle = -1;
    for (int k = 0; k < 8; k++) begin
      d_req = 1; d_addr = 32'(4 * k + 64);
      i_req = (gcycle < 0); i_addr = 32'h0000_0080;
      step();
      if (gi && gcycle < 0) gcycle = k;
    end
    check("starve_cycle", 32'(gcycle), 32'd4);
    idle();
    step(); step();

    // Held response while RAM output wanders, new request blocked meanwhile
    i_req = 1; i_addr = 32'h40;
    step();
    i_addr = 32'h44; i_rr = 0;
    step(); step(); step();
    i_rr = 1;
    step();
    idle();
    step(); step();

    // Eight back-to-back data reads
    for (int k = 0; k < 8; k++) begin
      d_req = 1; d_addr = 32'(4 * k);
      step();
    end
    idle();
    step(); step();

    // Reset asserted on the grant cycle of a read: no response follows
    i_req = 1; i_addr = 32'h8; s_rst = 1;
    step();
    idle();
    step(); step();

    // Random traffic
    gi = 0; gd = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!(i_req && !gi)) begin
        i_req   = ($urandom_range(0, 9) < 6);
        i_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        i_addr  = $urandom;
        i_wdata = $urandom;
      end
      if (!(d_req && !gd)) begin
        d_req   = ($urandom_range(0, 9) < 6);
        d_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      i_rr  = ($urandom_range(0, 3) != 0);
      d_rr  = ($urandom_range(0, 3) != 0);
      s_rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
